// File: rtl/diff_freq_pack_tx.sv
// diff_freq_pack_tx: latches output/freq patterns and a control byte and
// streams them as one byte pack through a UART transmitter handshake.

module diff_freq_pack_tx #(
  parameter int DATA_BIT    = 32,
  parameter int PACK_NUM    = (DATA_BIT / 8) * 2 + 1,
  parameter int GAP_CYCLES  = 0,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic [DATA_BIT-1:0] i_output_pattern,
  input  logic [DATA_BIT-1:0] i_freq_pattern,
  input  logic [7:0]          i_ctrl,
  input  logic                i_tx_done_tick,
  output logic                o_tx_start,
  output logic [7:0]          o_tx_data,
  output logic                o_busy,
  output logic                o_done_tick,
  output logic                o_timeout
);

  localparam int NB = DATA_BIT / 8;
  localparam int SW = 2 * DATA_BIT + 8;
  localparam int IW = $clog2(PACK_NUM + 1);
  localparam int GW = (GAP_CYCLES > 0) ?
                      $clog2(GAP_CYCLES + 1) : 1;
  localparam int TW = (TIMEOUT_CYC > 0) ?
                      $clog2(TIMEOUT_CYC + 1) : 1;

  localparam bit GAP_EN = (GAP_CYCLES > 0);
  localparam bit TO_EN  = (TIMEOUT_CYC > 0);

  localparam logic [IW-1:0] IDX_LAST = IW'(PACK_NUM - 1);
  localparam logic [GW-1:0] GAP_LAST =
    GW'(GAP_EN ? GAP_CYCLES - 1 : 0);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TO_EN ? TIMEOUT_CYC - 1 : 0);
  localparam logic [TW-1:0] TO_SAT = TW'(TIMEOUT_CYC);

  if (DATA_BIT < 8 || (DATA_BIT % 8) != 0 ||
      PACK_NUM != 2 * NB + 1) begin : g_bad_cfg
    $error("diff_freq_pack_tx: DATA_BIT must be a multiple of 8, PACK_NUM = 2*DATA_BIT/8+1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [IW-1:0] idx_q;
  logic [GW-1:0] gap_q;
  logic [TW-1:0] to_q;
  logic [SW-1:0] shift_q;
  logic [SW-1:0] shift_d;
  logic          start_q;
  logic          done_q;
  logic          tmo_q;

  logic accept;
  logic byte_ok;
  logic to_hit;

  assign accept  = (state_q == S_IDLE) && i_start;
  assign byte_ok = (state_q == S_WAIT) && i_tx_done_tick;
  // a done tick on the limit cycle wins over the timeout
  assign to_hit  = TO_EN && (state_q == S_WAIT) &&
                   !i_tx_done_tick && (to_q >= TO_LAST);

  // pack shifter: load on accepted start, drop one byte per completion
  always_comb begin
    shift_d = shift_q;
    if (accept) begin
      shift_d = {i_ctrl, i_freq_pattern, i_output_pattern};
    end else if (byte_ok) begin
      shift_d = shift_q >> 8;
    end
  end

  // pack shifter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  // framing FSM; to_q counts clocks since the current start pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      tmo_q   <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            idx_q   <= '0;
            to_q    <= '0;
            start_q <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          if (to_q != TO_SAT) begin
            to_q <= to_q + TW'(1);
          end
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (byte_ok) begin
            idx_q <= idx_q + IW'(1);
            if (idx_q == IDX_LAST) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (GAP_EN) begin
              gap_q   <= '0;
              state_q <= S_GAP;
            end else begin
              to_q    <= '0;
              start_q <= 1'b1;
              state_q <= S_SEND;
            end
          end else if (to_hit) begin
            tmo_q   <= 1'b1;
            state_q <= S_IDLE;
          end else if (to_q != TO_SAT) begin
            to_q <= to_q + TW'(1);
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            to_q    <= '0;
            start_q <= 1'b1;
            state_q <= S_SEND;
          end else begin
            gap_q <= gap_q + GW'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_tx_start  = start_q;
  assign o_tx_data   = shift_q[7:0];
  assign o_busy      = (state_q != S_IDLE);
  assign o_done_tick = done_q;
  assign o_timeout   = tmo_q;

endmodule

// File: tb/tb_diff_freq_pack_tx.sv
// tb_diff_freq_pack_tx: three instances (gap 0/5/2, 32/16-bit) driven by
// a UART responder and checked against a byte-list pack model.

module tb_diff_freq_pack_tx;

  logic clk;
  logic rst;
  int   cyc;

  logic        start_i [3];
  logic [31:0] pat_i   [2];
  logic [31:0] freq_i  [2];
  logic [15:0] pat2;
  logic [15:0] freq2;
  logic [7:0]  ctrl_i  [3];
  logic        tick_i  [3];
  logic        txs_o   [3];
  logic [7:0]  txd_o   [3];
  logic        busy_o  [3];
  logic        done_o  [3];
  logic        to_o    [3];

  int          st_cyc [3][$];
  int          tk_cyc [3][$];
  int          dn_cyc [3][$];
  int          to_cyc [3][$];
  logic [7:0]  byt    [3][$];
  int          stab_err [3];
  int          delay    [3];
  int          hold_abs [3];
  int          gapv     [3];

  int n_tests;
  int n_fail;

  typedef struct {
    int st;
    int tk;
    int dn;
    int to;
    int se;
  } base_t;

  typedef struct {
    int          k;
    logic [31:0] p;
    logic [31:0] f;
    logic [7:0]  c;
    int          n;
    logic [71:0] e;
  } vec_t;

  diff_freq_pack_tx #(
    .DATA_BIT(32), .GAP_CYCLES(0), .TIMEOUT_CYC(100)
  ) dut0 (
    .clk(clk), .rst(rst), .i_start(start_i[0]),
    .i_output_pattern(pat_i[0]), .i_freq_pattern(freq_i[0]),
    .i_ctrl(ctrl_i[0]), .i_tx_done_tick(tick_i[0]),
    .o_tx_start(txs_o[0]), .o_tx_data(txd_o[0]),
    .o_busy(busy_o[0]), .o_done_tick(done_o[0]),
    .o_timeout(to_o[0])
  );

  diff_freq_pack_tx #(
    .DATA_BIT(32), .GAP_CYCLES(5), .TIMEOUT_CYC(0)
  ) dut1 (
    .clk(clk), .rst(rst), .i_start(start_i[1]),
    .i_output_pattern(pat_i[1]), .i_freq_pattern(freq_i[1]),
    .i_ctrl(ctrl_i[1]), .i_tx_done_tick(tick_i[1]),
    .o_tx_start(txs_o[1]), .o_tx_data(txd_o[1]),
    .o_busy(busy_o[1]), .o_done_tick(done_o[1]),
    .o_timeout(to_o[1])
  );

  diff_freq_pack_tx #(
    .DATA_BIT(16), .GAP_CYCLES(2), .TIMEOUT_CYC(0)
  ) dut2 (
    .clk(clk), .rst(rst), .i_start(start_i[2]),
    .i_output_pattern(pat2), .i_freq_pattern(freq2),
    .i_ctrl(ctrl_i[2]), .i_tx_done_tick(tick_i[2]),
    .o_tx_start(txs_o[2]), .o_tx_data(txd_o[2]),
    .o_busy(busy_o[2]), .o_done_tick(done_o[2]),
    .o_timeout(to_o[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // UART responder and event recorder for all instances
  initial begin
    int         rem  [3];
    logic       pend [3];
    logic [7:0] cur  [3];
    for (int k = 0; k < 3; k++) begin
      tick_i[k]   = 1'b0;
      pend[k]     = 1'b0;
      rem[k]      = 0;
      cur[k]      = '0;
      stab_err[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        tick_i[k] = 1'b0;
        if (rst) begin
          pend[k] = 1'b0;
        end else begin
          if (pend[k]) begin
            if (txd_o[k] !== cur[k]) stab_err[k]++;
            rem[k]--;
            if (rem[k] == 0) begin
              tick_i[k] = 1'b1;
              pend[k]   = 1'b0;
              tk_cyc[k].push_back(cyc);
            end
          end
          if (txs_o[k] === 1'b1) begin
            byt[k].push_back(txd_o[k]);
            st_cyc[k].push_back(cyc);
            if (byt[k].size() - 1 != hold_abs[k]) begin
              pend[k] = 1'b1;
              rem[k]  = delay[k];
              cur[k]  = txd_o[k];
            end
          end
          if (done_o[k] === 1'b1) dn_cyc[k].push_back(cyc);
          if (to_o[k] === 1'b1) to_cyc[k].push_back(cyc);
        end
      end
    end
  end

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endfunction

  function automatic void bound_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: DUT event did not arrive in budget", nm);
  endfunction

  // pack = output pattern bytes, freq pattern bytes (LSB first), ctrl
  function automatic void model(input int nb,
                                input logic [31:0] p,
                                input logic [31:0] f,
                                input logic [7:0] c,
                                output logic [7:0] q[$]);
    q = {};
    for (int i = 0; i < nb; i++) q.push_back(8'(p >> (8 * i)));
    for (int i = 0; i < nb; i++) q.push_back(8'(f >> (8 * i)));
    q.push_back(c);
  endfunction

  function automatic base_t snap(input int k);
    base_t b;
    b.st = st_cyc[k].size();
    b.tk = tk_cyc[k].size();
    b.dn = dn_cyc[k].size();
    b.to = to_cyc[k].size();
    b.se = stab_err[k];
    return b;
  endfunction

  task automatic set_in(input int k, input logic [31:0] p,
                        input logic [31:0] f, input logic [7:0] c);
    if (k < 2) begin
      pat_i[k]  = p;
      freq_i[k] = f;
    end else begin
      pat2  = p[15:0];
      freq2 = f[15:0];
    end
    ctrl_i[k] = c;
  endtask

  task automatic begin_pack(input int k, input logic [31:0] p,
                            input logic [31:0] f, input logic [7:0] c,
                            output int t0);
    @(negedge clk);
    set_in(k, p, f, c);
    start_i[k] = 1'b1;
    t0 = cyc;
    @(negedge clk);
    start_i[k] = 1'b0;
    set_in(k, ~p, ~f, ~c);
  endtask

  task automatic wait_end(input int k, input base_t b, input string nm);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
      if (dn_cyc[k].size() > b.dn || to_cyc[k].size() > b.to)
        seen = 1'b1;
    end
    if (!seen) begin
      bound_fail({nm, "_end"});
    end else if (dn_cyc[k].size() > b.dn) begin
      chk({nm, "_busy_at_done"}, 64'(busy_o[k]), 64'd1);
      @(negedge clk);
      #1;
      chk({nm, "_busy_after_done"}, 64'(busy_o[k]), 64'd0);
    end else begin
      chk({nm, "_busy_at_timeout"}, 64'(busy_o[k]), 64'd0);
    end
    repeat (20) @(negedge clk);
    #1;
  endtask

  task automatic verify_ok(input int k, input base_t b,
                           input logic [7:0] want[$], input int t0,
                           input string nm);
    int ns;
    int nd;
    ns = st_cyc[k].size() - b.st;
    nd = dn_cyc[k].size() - b.dn;
    chk({nm, "_nstart"}, 64'(ns), 64'(want.size()));
    chk({nm, "_ndone"}, 64'(nd), 64'd1);
    chk({nm, "_ntimeout"}, 64'(to_cyc[k].size() - b.to), 64'd0);
    chk({nm, "_stable"}, 64'(stab_err[k] - b.se), 64'd0);
    if (ns > 0)
      chk({nm, "_first_start"}, 64'(st_cyc[k][b.st]), 64'(t0 + 1));
    for (int i = 0; i < ns && i < want.size(); i++) begin
      chk($sformatf("%s_byte%0d", nm, i), 64'(byt[k][b.st + i]),
          64'(want[i]));
      if (i > 0 && tk_cyc[k].size() > b.tk + i - 1)
        chk($sformatf("%s_gap%0d", nm, i),
            64'(st_cyc[k][b.st + i] - tk_cyc[k][b.tk + i - 1]),
            64'(gapv[k] + 1));
    end
    if (nd > 0 && ns > 0 && tk_cyc[k].size() >= b.tk + ns)
      chk({nm, "_done_time"}, 64'(dn_cyc[k][b.dn]),
          64'(tk_cyc[k][b.tk + ns - 1] + 1));
  endtask

  initial begin
    vec_t       tbl [4];
    base_t      b;
    logic [7:0] q[$];
    int         t0;
    int         n;
    int         k;
    logic [31:0] p;
    logic [31:0] f;
    logic [7:0]  c;

    n_tests = 0;
    n_fail  = 0;
    gapv    = '{0, 5, 2};
    delay   = '{20, 20, 3};
    hold_abs = '{-1, -1, -1};
    tbl[0] = '{0, 32'h12345678, 32'hA5A50F0F, 8'h81, 9,
               72'h78_56_34_12_0F_0F_A5_A5_81};
    tbl[1] = '{2, 32'h0000BEEF, 32'h00000102, 8'h3C, 5,
               72'hEF_BE_02_01_3C};
    tbl[2] = '{1, 32'hDEADBEEF, 32'h00FF00FF, 8'h00, 9,
               72'hEF_BE_AD_DE_FF_00_FF_00_00};
    tbl[3] = '{0, 32'h00000000, 32'hFFFFFFFF, 8'hFF, 9,
               72'h00_00_00_00_FF_FF_FF_FF_FF};

    rst = 1'b1;
    pat2 = '0;
    freq2 = '0;
    for (int i = 0; i < 3; i++) begin
      start_i[i] = 1'b0;
      ctrl_i[i]  = '0;
    end
    for (int i = 0; i < 2; i++) begin
      pat_i[i]  = '0;
      freq_i[i] = '0;
    end

    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_tx_start%0d", i), 64'(txs_o[i]), 64'd0);
      chk($sformatf("rst_tx_data%0d", i), 64'(txd_o[i]), 64'd0);
      chk($sformatf("rst_busy%0d", i), 64'(busy_o[i]), 64'd0);
      chk($sformatf("rst_done%0d", i), 64'(done_o[i]), 64'd0);
      chk($sformatf("rst_timeout%0d", i), 64'(to_o[i]), 64'd0);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      q = {};
      for (int i = 0; i < tbl[v].n; i++)
        q.push_back(tbl[v].e[8 * (tbl[v].n - 1 - i) +: 8]);
      b = snap(tbl[v].k);
      begin_pack(tbl[v].k, tbl[v].p, tbl[v].f, tbl[v].c, t0);
      wait_end(tbl[v].k, b, $sformatf("vec%0d", v));
      verify_ok(tbl[v].k, b, q, t0, $sformatf("vec%0d", v));
    end

    model(4, 32'h12345678, 32'hA5A50F0F, 8'h81, q);
    b = snap(0);
    begin_pack(0, 32'h12345678, 32'hA5A50F0F, 8'h81, t0);
    repeat (50) @(negedge clk);
    set_in(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 8'hFF);
    start_i[0] = 1'b1;
    @(negedge clk);
    start_i[0] = 1'b0;
    wait_end(0, b, "busy_start");
    verify_ok(0, b, q, t0, "busy_start");

    for (int r = 0; r < 8; r++) begin
      k = int'($urandom_range(0, 2));
      delay[k] = int'($urandom_range(1, 12));
      p = $urandom;
      f = $urandom;
      c = 8'($urandom);
      model((k == 2) ? 2 : 4, p, f, c, q);
      b = snap(k);
      begin_pack(k, p, f, c, t0);
      wait_end(k, b, $sformatf("rnd%0d", r));
      verify_ok(k, b, q, t0, $sformatf("rnd%0d", r));
    end

    delay[0] = 20;
    hold_abs[0] = byt[0].size() + 3;
    b = snap(0);
    begin_pack(0, 32'hCAFEF00D, 32'h13572468, 8'h5A, t0);
    wait_end(0, b, "hold3");
    hold_abs[0] = -1;
    chk("hold3_ntimeout", 64'(to_cyc[0].size() - b.to), 64'd1);
    chk("hold3_ndone", 64'(dn_cyc[0].size() - b.dn), 64'd0);
    chk("hold3_nstart", 64'(st_cyc[0].size() - b.st), 64'd4);
    if (to_cyc[0].size() > b.to && st_cyc[0].size() > b.st + 3)
      chk("hold3_timeout_time", 64'(to_cyc[0][b.to]),
          64'(st_cyc[0][b.st + 3] + 100));

    model(4, 32'h0BADC0DE, 32'h55AA55AA, 8'h7E, q);
    b = snap(0);
    begin_pack(0, 32'h0BADC0DE, 32'h55AA55AA, 8'h7E, t0);
    wait_end(0, b, "after_to");
    verify_ok(0, b, q, t0, "after_to");

    delay[0] = 99;
    model(4, 32'h89ABCDEF, 32'h01234567, 8'hC3, q);
    b = snap(0);
    begin_pack(0, 32'h89ABCDEF, 32'h01234567, 8'hC3, t0);
    wait_end(0, b, "edge99");
    verify_ok(0, b, q, t0, "edge99");

    delay[0] = 100;
    b = snap(0);
    begin_pack(0, 32'h11112222, 32'h33334444, 8'h55, t0);
    wait_end(0, b, "edge100");
    chk("edge100_ntimeout", 64'(to_cyc[0].size() - b.to), 64'd1);
    chk("edge100_ndone", 64'(dn_cyc[0].size() - b.dn), 64'd0);
    chk("edge100_nstart", 64'(st_cyc[0].size() - b.st), 64'd1);
    if (to_cyc[0].size() > b.to && st_cyc[0].size() > b.st)
      chk("edge100_timeout_time", 64'(to_cyc[0][b.to]),
          64'(st_cyc[0][b.st] + 100));

    delay[0] = 20;
    b = snap(0);
    begin_pack(0, 32'hA1B2C3D4, 32'hE5F60718, 8'h29, t0);
    n = 0;
    while (st_cyc[0].size() < b.st + 5 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (st_cyc[0].size() < b.st + 5) bound_fail("rst_mid_byte4");
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rstmid_tx_start", 64'(txs_o[0]), 64'd0);
    chk("rstmid_tx_data", 64'(txd_o[0]), 64'd0);
    chk("rstmid_busy", 64'(busy_o[0]), 64'd0);
    chk("rstmid_done", 64'(done_o[0]), 64'd0);
    chk("rstmid_timeout", 64'(to_o[0]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    b = snap(0);
    repeat (40) @(negedge clk);
    #1;
    chk("rstmid_quiet_start", 64'(st_cyc[0].size() - b.st), 64'd0);
    chk("rstmid_quiet_done", 64'(dn_cyc[0].size() - b.dn), 64'd0);
    chk("rstmid_quiet_to", 64'(to_cyc[0].size() - b.to), 64'd0);

    model(4, 32'h12345678, 32'hA5A50F0F, 8'h81, q);
    b = snap(0);
    begin_pack(0, 32'h12345678, 32'hA5A50F0F, 8'h81, t0);
    wait_end(0, b, "after_rst");
    verify_ok(0, b, q, t0, "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/diff_freq_pack_tx.md
Name: diff_freq_pack_tx

Overview:
- Host-side framer: latches one output pattern, one frequency pattern and one control byte, then emits them as a PACK_NUM-byte pack through a UART transmitter.
- Byte-level handshake with the UART: one start pulse per byte, wait for the UART tx done tick.
- Produces exactly the pack format consumed by diff_freq_serial_out.
- Used in loopback benches and in FPGA-to-FPGA links where a second board drives the serial-out block.

Parameters:
- DATA_BIT, 32: width of each pattern; must be a multiple of 8; elaboration error otherwise.
- PACK_NUM, (DATA_BIT/8)*2+1: bytes per pack.
- GAP_CYCLES, 0: idle clocks between a byte's done tick and the next byte's start pulse.
- TIMEOUT_CYC, 0: max clocks to wait for i_tx_done_tick per byte; 0 disables the timeout.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous reset, active-high
- i_start  input  1  single-cycle request to send a pack
- i_output_pattern  input  DATA_BIT  output pattern, sampled on accepted i_start
- i_freq_pattern  input  DATA_BIT  frequency pattern, sampled on accepted i_start
- i_ctrl  input  8  control byte, sampled on accepted i_start
- i_tx_done_tick  input  1  UART byte-complete pulse
- o_tx_start  output  1  one-cycle pulse; UART start
- o_tx_data  output  8  byte to transmit; valid and stable from the o_tx_start cycle until that byte's done tick
- o_busy  output  1  high from the cycle after accepted i_start until return to IDLE
- o_done_tick  output  1  one-cycle pulse; pack fully sent
- o_timeout  output  1  one-cycle pulse; pack aborted

Behaviour:
- Reset (async, any state): state=IDLE. o_tx_start=0, o_tx_data=0, o_busy=0, o_done_tick=0, o_timeout=0. Byte index, gap counter and timeout counter = 0. A pack in flight is discarded; no done or timeout pulse.
- Byte order: byte 0..DATA_BIT/8-1 = output pattern, LSB byte first. Next DATA_BIT/8 bytes = freq pattern, LSB byte first. Last byte = i_ctrl.
- Shift register: latched into a PACK_NUM*8-bit shift register. o_tx_data = low byte. Shift right by 8 on each byte completion.
- States: IDLE, SEND, WAIT, GAP, DONE.
  - IDLE: i_start=1 at edge N → latch inputs, index=0 → SEND. Otherwise hold.
  - SEND: o_tx_start=1 for exactly this cycle; i.e. cycle N+1 for byte 0 → WAIT. Timeout counter cleared.
  - WAIT: i_tx_done_tick=1 → index++ and shift.
    - index was PACK_NUM-1 → DONE.
    - Else GAP_CYCLES>0 → GAP; GAP_CYCLES=0 → SEND.
  - WAIT timeout: TIMEOUT_CYC>0 and timeout counter reaches TIMEOUT_CYC-1 with no done tick → o_timeout pulse next cycle, → IDLE.
  - GAP: count GAP_CYCLES clocks → SEND. i_tx_done_tick is ignored here.
  - DONE: o_done_tick=1 for one cycle → IDLE.
- o_busy = (state != IDLE).
- Ignored inputs:
  - i_start while not IDLE: ignored; inputs are not re-latched.
  - i_tx_done_tick in IDLE, SEND or GAP: ignored.
- A done tick in the same cycle as the timeout limit counts as success.
- Counters:
  - Byte index width = $clog2(PACK_NUM+1).
  - Gap counter width = $clog2(GAP_CYCLES+1), minimum 1.
  - Timeout counter width = $clog2(TIMEOUT_CYC+1), minimum 1.
  - No counter wraps; each is cleared on state entry.
- A new i_start is accepted in the IDLE cycle immediately after DONE.

Test Plan:
- Normal pack: pattern 0x12345678, freq 0xA5A50F0F, ctrl 0x81; bench model returns done tick 20 cycles after each start → o_tx_data sequence 78 56 34 12 0F 0F A5 A5 81. Exactly 9 o_tx_start pulses; one o_done_tick one cycle after the 9th done tick; o_busy deasserts the next cycle.
- Start during busy: second i_start with pattern 0xFFFFFFFF mid-pack → ignored; original bytes sent unchanged; only one o_done_tick.
- Gap: GAP_CYCLES=5 → each o_tx_start after the first occurs exactly 6 cycles after the preceding done tick. With GAP_CYCLES=0, exactly 1 cycle after.
- Timeout: TIMEOUT_CYC=100; model withholds the done tick on byte 3 → o_timeout pulse 100 cycles after that start; no o_done_tick; IDLE; a new pack then completes normally.
- Reset mid-pack: assert rst during byte 4 WAIT → all outputs 0 immediately (asynchronous); no pulses after release; next i_start sends from byte 0.
- DATA_BIT=16 instance: pattern 0xBEEF, freq 0x0102, ctrl 0x3C → bytes EF BE 02 01 3C; PACK_NUM=5.
